// File: rtl/axi_rd_arbiter2.sv
// rtl/axi_rd_arbiter2.sv - 2:1 round-robin AXI4 read arbiter, one burst in flight
module axi_rd_arbiter2 #(
    parameter int ADDRS    = 29,
    parameter int ID_WIDTH = 4,
    parameter int WIDTH    = 32
) (
    input  logic                clock,
    input  logic                arst_n,
    input  logic                s0_arvalid_i,
    output logic                s0_arready_o,
    input  logic [ADDRS-1:0]    s0_araddr_i,
    input  logic [ID_WIDTH-1:0] s0_arid_i,
    input  logic [7:0]          s0_arlen_i,
    input  logic [1:0]          s0_arburst_i,
    output logic                s0_rvalid_o,
    input  logic                s0_rready_i,
    output logic                s0_rlast_o,
    output logic [1:0]          s0_rresp_o,
    output logic [ID_WIDTH-1:0] s0_rid_o,
    output logic [WIDTH-1:0]    s0_rdata_o,
    input  logic                s1_arvalid_i,
    output logic                s1_arready_o,
    input  logic [ADDRS-1:0]    s1_araddr_i,
    input  logic [ID_WIDTH-1:0] s1_arid_i,
    input  logic [7:0]          s1_arlen_i,
    input  logic [1:0]          s1_arburst_i,
    output logic                s1_rvalid_o,
    input  logic                s1_rready_i,
    output logic                s1_rlast_o,
    output logic [1:0]          s1_rresp_o,
    output logic [ID_WIDTH-1:0] s1_rid_o,
    output logic [WIDTH-1:0]    s1_rdata_o,
    output logic                m_arvalid_o,
    input  logic                m_arready_i,
    output logic [ADDRS-1:0]    m_araddr_o,
    output logic [ID_WIDTH-1:0] m_arid_o,
    output logic [7:0]          m_arlen_o,
    output logic [1:0]          m_arburst_o,
    input  logic                m_rvalid_i,
    input  logic                m_rlast_i,
    input  logic [1:0]          m_rresp_i,
    input  logic [ID_WIDTH-1:0] m_rid_i,
    input  logic [WIDTH-1:0]    m_rdata_i,
    output logic                m_rready_o,
    output logic                err_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                prio_q, prio_d;
    logic                grant_q, grant_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [7:0]          len_q, len_d;
    logic [ADDRS-1:0]    addr_q, addr_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [1:0]          burst_q, burst_d;
    logic                err_q, err_d;

    logic in_idle, in_data, sel, ar_take, r_beat;

    assign in_idle = (state_q == S_IDLE);
    assign in_data = (state_q == S_DATA);
    // prio_q only matters on a tie; a lone requester always wins
    assign sel     = (s0_arvalid_i && s1_arvalid_i) ? prio_q : s1_arvalid_i;
    assign ar_take = in_idle && arst_n && (s0_arvalid_i || s1_arvalid_i);

    assign s0_arready_o = ar_take && !sel;
    assign s1_arready_o = ar_take && sel;

    assign m_arvalid_o = (state_q == S_ADDR);
    assign m_araddr_o  = addr_q;
    assign m_arid_o    = id_q;
    assign m_arlen_o   = len_q;
    assign m_arburst_o = burst_q;

    assign m_rready_o  = in_data && (grant_q ? s1_rready_i : s0_rready_i);
    assign s0_rvalid_o = in_data && !grant_q && m_rvalid_i;
    assign s1_rvalid_o = in_data && grant_q && m_rvalid_i;
    assign r_beat      = m_rvalid_i && m_rready_o;

    assign s0_rlast_o = m_rlast_i;
    assign s0_rresp_o = m_rresp_i;
    assign s0_rid_o   = m_rid_i;
    assign s0_rdata_o = m_rdata_i;
    assign s1_rlast_o = m_rlast_i;
    assign s1_rresp_o = m_rresp_i;
    assign s1_rid_o   = m_rid_i;
    assign s1_rdata_o = m_rdata_i;

    assign err_o = err_q;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        addr_d  = addr_q;
        id_d    = id_q;
        burst_d = burst_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (ar_take) begin
                    grant_d = sel;
                    cnt_d   = 8'd0;
                    addr_d  = sel ? s1_araddr_i  : s0_araddr_i;
                    id_d    = sel ? s1_arid_i    : s0_arid_i;
                    len_d   = sel ? s1_arlen_i   : s0_arlen_i;
                    burst_d = sel ? s1_arburst_i : s0_arburst_i;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (m_arready_i) state_d = S_DATA;
            end
            S_DATA: begin
                if (r_beat) begin
                    cnt_d = cnt_q + 8'd1;
                    // Flag a short or long burst; the burst still ends only on rlast
                    if ((m_rlast_i && cnt_q != len_q) || (!m_rlast_i && cnt_q == len_q))
                        err_d = 1'b1;
                    if (m_rlast_i) begin
                        state_d = S_IDLE;
                        prio_d  = ~grant_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            grant_q <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            id_q    <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            burst_q <= burst_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_axi_rd_arbiter2.sv
// tb/tb_axi_rd_arbiter2.sv - directed self-checking bench for axi_rd_arbiter2
module tb_axi_rd_arbiter2;
    localparam int ADDRS    = 29;
    localparam int ID_WIDTH = 4;
    localparam int WIDTH    = 32;

    logic clock = 1'b0;
    logic arst_n = 1'b0;

    logic                s0_arvalid = 0, s1_arvalid = 0;
    logic                s0_arready, s1_arready;
    logic [ADDRS-1:0]    s0_araddr = '0, s1_araddr = '0;
    logic [ID_WIDTH-1:0] s0_arid = '0, s1_arid = '0;
    logic [7:0]          s0_arlen = '0, s1_arlen = '0;
    logic [1:0]          s0_arburst = '0, s1_arburst = '0;
    logic                s0_rvalid, s1_rvalid;
    logic                s0_rready = 1, s1_rready = 1;
    logic                s0_rlast, s1_rlast;
    logic [1:0]          s0_rresp, s1_rresp;
    logic [ID_WIDTH-1:0] s0_rid, s1_rid;
    logic [WIDTH-1:0]    s0_rdata, s1_rdata;
    logic                m_arvalid;
    logic                m_arready = 0;
    logic [ADDRS-1:0]    m_araddr;
    logic [ID_WIDTH-1:0] m_arid;
    logic [7:0]          m_arlen;
    logic [1:0]          m_arburst;
    logic                m_rvalid = 0, m_rlast = 0;
    logic [1:0]          m_rresp = '0;
    logic [ID_WIDTH-1:0] m_rid = '0;
    logic [WIDTH-1:0]    m_rdata = '0;
    logic                m_rready;
    logic                err;

    int n_tests = 0;
    int n_fail  = 0;

    axi_rd_arbiter2 #(.ADDRS(ADDRS), .ID_WIDTH(ID_WIDTH), .WIDTH(WIDTH)) dut (
        .clock(clock), .arst_n(arst_n),
        .s0_arvalid_i(s0_arvalid), .s0_arready_o(s0_arready), .s0_araddr_i(s0_araddr),
        .s0_arid_i(s0_arid), .s0_arlen_i(s0_arlen), .s0_arburst_i(s0_arburst),
        .s0_rvalid_o(s0_rvalid), .s0_rready_i(s0_rready), .s0_rlast_o(s0_rlast),
        .s0_rresp_o(s0_rresp), .s0_rid_o(s0_rid), .s0_rdata_o(s0_rdata),
        .s1_arvalid_i(s1_arvalid), .s1_arready_o(s1_arready), .s1_araddr_i(s1_araddr),
        .s1_arid_i(s1_arid), .s1_arlen_i(s1_arlen), .s1_arburst_i(s1_arburst),
        .s1_rvalid_o(s1_rvalid), .s1_rready_i(s1_rready), .s1_rlast_o(s1_rlast),
        .s1_rresp_o(s1_rresp), .s1_rid_o(s1_rid), .s1_rdata_o(s1_rdata),
        .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr),
        .m_arid_o(m_arid), .m_arlen_o(m_arlen), .m_arburst_o(m_arburst),
        .m_rvalid_i(m_rvalid), .m_rlast_i(m_rlast), .m_rresp_i(m_rresp),
        .m_rid_i(m_rid), .m_rdata_i(m_rdata), .m_rready_o(m_rready), .err_o(err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        arst_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        arst_n = 1'b1;
    endtask

    // Called at a negedge in ADDR: accept the AR after one cycle, land in DATA
    task automatic accept_ar();
        m_arready = 1'b1;
        @(negedge clock);
        m_arready = 1'b0;
    endtask

    // Controller returns n beats; rlast placed on beat index last_idx
    task automatic send_beats(input int port, input int n, input int last_idx);
        for (int i = 0; i < n; i++) begin
            m_rvalid = 1'b1;
            m_rlast  = (i == last_idx);
            m_rdata  = 32'hD000 + i;
            m_rid    = 4'(i);
            #1;
            check("beat_m_rready", m_rready, 1);
            check("beat_rvalid_granted", port ? s1_rvalid : s0_rvalid, 1);
            check("beat_rvalid_other", port ? s0_rvalid : s1_rvalid, 0);
            check("beat_rdata", port ? s1_rdata : s0_rdata, 32'hD000 + i);
            @(negedge clock);
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    initial begin
        int beats;
        int k;

        // Reset state, with an AR pending to prove arready stays low
        s0_arvalid = 1'b1;
        @(negedge clock);
        #1;
        check("rst_arready0", s0_arready, 0);
        check("rst_m_arvalid", m_arvalid, 0);
        check("rst_m_rready", m_rready, 0);
        check("rst_err", err, 0);
        check("rst_araddr", m_araddr, 0);
        check("rst_arlen", m_arlen, 0);
        s0_arvalid = 1'b0;
        @(negedge clock);
        arst_n = 1'b1;
        @(negedge clock);

        // 1: lone S0 request, len 3
        s0_arvalid = 1; s0_araddr = 29'h100; s0_arid = 4'h5; s0_arlen = 8'd3; s0_arburst = 2'b01;
        #1;
        check("t1_s0_arready", s0_arready, 1);
        check("t1_s1_arready", s1_arready, 0);
        check("t1_m_arvalid_early", m_arvalid, 0);
        @(negedge clock);
        s0_arvalid = 0;
        #1;
        check("t1_m_arvalid", m_arvalid, 1);
        check("t1_araddr", m_araddr, 29'h100);
        check("t1_arlen", m_arlen, 3);
        check("t1_arid", m_arid, 5);
        check("t1_arburst", m_arburst, 1);
        check("t1_arready_addr", s0_arready, 0);
        accept_ar();
        send_beats(0, 4, 3);
        #1;
        check("t1_rready_idle", m_rready, 0);
        check("t1_err", err, 0);

        // 2: simultaneous requests after reset -> S0, S1, then S0 again
        do_reset();
        s0_arvalid = 1; s0_araddr = 29'h200; s0_arlen = 8'd0;
        s1_arvalid = 1; s1_araddr = 29'h300; s1_arlen = 8'd0; s1_arid = 4'h9;
        #1;
        check("t2_s0_wins", s0_arready, 1);
        check("t2_s1_waits", s1_arready, 0);
        @(negedge clock);
        s0_arvalid = 0;
        #1;
        check("t2_addr0", m_araddr, 29'h200);
        check("t2_s1_blocked_addr", s1_arready, 0);
        accept_ar();
        #1;
        check("t2_s1_blocked_data", s1_arready, 0);
        send_beats(0, 1, 0);
        #1;
        check("t2_s1_served", s1_arready, 1);
        @(negedge clock);
        s1_arvalid = 0;
        #1;
        check("t2_addr1", m_araddr, 29'h300);
        check("t2_id1", m_arid, 9);
        accept_ar();
        send_beats(1, 1, 0);
        s0_arvalid = 1; s0_araddr = 29'h400; s0_arlen = 8'd0;
        s1_arvalid = 1;
        #1;
        check("t2_again_s0", s0_arready, 1);
        check("t2_again_s1", s1_arready, 0);
        @(negedge clock);
        s0_arvalid = 0; s1_arvalid = 0;

        // 3: controller stalls AR for 5 cycles
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_arvalid_hold", m_arvalid, 1);
            check("t3_araddr_hold", m_araddr, 29'h400);
            check("t3_arlen_hold", m_arlen, 0);
            @(negedge clock);
        end
        accept_ar();
        send_beats(0, 1, 0);

        // 4: S1 len 7 with rready toggling 1010...
        s1_arvalid = 1; s1_araddr = 29'h500; s1_arlen = 8'd7;
        @(negedge clock);
        s1_arvalid = 0;
        accept_ar();
        beats = 0;
        k = 0;
        while (beats < 8 && k < 40) begin
            s1_rready = (k % 2 == 0);
            m_rvalid  = 1'b1;
            m_rlast   = (beats == 7);
            m_rdata   = 32'hE000 + beats;
            #1;
            check("t4_rready_mirror", m_rready, s1_rready);
            check("t4_s0_rvalid", s0_rvalid, 0);
            if (m_rready) begin
                check("t4_rdata", s1_rdata, 32'hE000 + beats);
                beats++;
            end
            @(negedge clock);
            k++;
        end
        m_rvalid = 0; m_rlast = 0; s1_rready = 1;
        check("t4_beats", beats, 8);
        #1;
        check("t4_err", err, 0);
        check("t4_idle_rready", m_rready, 0);

        // 5: len 3 but rlast on third beat -> sticky error
        @(negedge clock);
        s0_arvalid = 1; s0_araddr = 29'h600; s0_arlen = 8'd3;
        @(negedge clock);
        s0_arvalid = 0;
        accept_ar();
        send_beats(0, 3, 2);
        #1;
        check("t5_err_set", err, 1);
        check("t5_idle", m_rready, 0);
        s1_arvalid = 1; s1_araddr = 29'h700; s1_arlen = 8'd1;
        #1;
        check("t5_next_arready", s1_arready, 1);
        @(negedge clock);
        s1_arvalid = 0;
        accept_ar();
        send_beats(1, 2, 1);
        #1;
        check("t5_err_sticky", err, 1);

        // 6: reset during beat 2 of a len-3 burst
        @(negedge clock);
        s0_arvalid = 1; s0_araddr = 29'h800; s0_arlen = 8'd3;
        @(negedge clock);
        s0_arvalid = 0;
        accept_ar();
        send_beats(0, 2, 99);
        m_rvalid = 1;
        #1;
        check("t6_beat2_live", s0_rvalid, 1);
        arst_n = 0;
        #1;
        check("t6_rvalid_rst", s0_rvalid, 0);
        check("t6_rready_rst", m_rready, 0);
        check("t6_arvalid_rst", m_arvalid, 0);
        check("t6_err_rst", err, 0);
        check("t6_araddr_rst", m_araddr, 0);
        @(negedge clock);
        arst_n = 1;
        #1;
        check("t6_idle_rready", m_rready, 0);
        check("t6_idle_rvalid", s0_rvalid, 0);
        m_rvalid = 0;
        s1_arvalid = 1; s1_araddr = 29'h900; s1_arlen = 8'd0;
        #1;
        check("t6_after_arready", s1_arready, 1);
        @(negedge clock);
        s1_arvalid = 0;
        #1;
        check("t6_after_araddr", m_araddr, 29'h900);
        accept_ar();
        send_beats(1, 1, 0);
        #1;
        check("t6_after_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
